// File: rtl/ro_sched_mux.sv
// ro_sched_mux: gray-scheduled time-division readout mux for N_CH channel cores.
// Captures rising event edges with polarity, buffers one per channel, and
// serialises them in gray-counter slots so channel k runs at its octave rate.
//
// Parameters:
//   N_CH  number of channels (2..16)
//   CH_W  channel index width, $clog2(N_CH) with a minimum of 1
// Ports:
//   clk_master       master clock, rising edge
//   reset            asynchronous active-high reset
//   en               advance the slot schedule
//   in_eve           per-channel event level from the cores
//   in_pol_eve       per-channel polarity, sampled with in_eve
//   ovf_clr          clear all overflow flags
//   gray             registered gray code of the slot counter
//   out_mux_eve      event present in the current slot
//   out_mux_pol_eve  polarity of that event, 0 when none
//   out_ch           channel serviced in the current slot
//   out_frame        last slot of each 2^N_CH-cycle frame
//   ovf              sticky per-channel overflow flags
//
// Configuration macro RO_SYNC_EN: when defined, every in_eve/in_pol_eve bit
// passes a two-flop synchroniser (D=2); otherwise a single sample flop (D=1)
// and inputs must be synchronous to clk_master.

module ro_sched_mux #(
    parameter int N_CH = 8,
    parameter int CH_W = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH)
) (
    input  logic            clk_master,
    input  logic            reset,
    input  logic            en,
    input  logic [N_CH-1:0] in_eve,
    input  logic [N_CH-1:0] in_pol_eve,
    input  logic            ovf_clr,
    output logic [N_CH-1:0] gray,
    output logic            out_mux_eve,
    output logic            out_mux_pol_eve,
    output logic [CH_W-1:0] out_ch,
    output logic            out_frame,
    output logic [N_CH-1:0] ovf
);

    logic [N_CH-1:0] r_cnt;
    logic [N_CH-1:0] r_gray;
    logic [N_CH-1:0] r_pend;
    logic [N_CH-1:0] r_pol;
    logic [N_CH-1:0] r_ovf;
    logic [N_CH-1:0] r_eve0;
    logic [N_CH-1:0] r_eve1;
    logic [N_CH-1:0] r_pol0;
    logic            r_out_eve;
    logic            r_out_pol;
    logic [CH_W-1:0] r_out_ch;
    logic            r_out_frame;

    logic [N_CH-1:0] w_cnt_inc;
    logic [CH_W-1:0] w_slot;
    logic [N_CH-1:0] w_clr;
    logic [N_CH-1:0] w_edge;
    logic [N_CH-1:0] w_pend_nxt;
    logic [N_CH-1:0] w_pol_ld;
    logic [N_CH-1:0] w_pol_nxt;
    logic [N_CH-1:0] w_ovf_set;
    logic [N_CH-1:0] w_ovf_nxt;

    // Input sample stages; r_eve0/r_pol0 are the last stage in both builds.
`ifdef RO_SYNC_EN
    logic [N_CH-1:0] r_eve_m;
    logic [N_CH-1:0] r_pol_m;

    always_ff @(posedge clk_master or posedge reset) begin
        if (reset) begin
            r_eve_m <= '0;
            r_pol_m <= '0;
            r_eve0  <= '0;
            r_pol0  <= '0;
        end else begin
            r_eve_m <= in_eve;
            r_pol_m <= in_pol_eve;
            r_eve0  <= r_eve_m;
            r_pol0  <= r_pol_m;
        end
    end
`else
    always_ff @(posedge clk_master or posedge reset) begin
        if (reset) begin
            r_eve0 <= '0;
            r_pol0 <= '0;
        end else begin
            r_eve0 <= in_eve;
            r_pol0 <= in_pol_eve;
        end
    end
`endif

    always_ff @(posedge clk_master or posedge reset) begin
        if (reset) begin
            r_eve1 <= '0;
        end else begin
            r_eve1 <= r_eve0;
        end
    end

    assign w_edge    = r_eve0 & ~r_eve1;
    assign w_cnt_inc = r_cnt + {{(N_CH-1){1'b0}}, 1'b1};

    // Lowest set bit of cnt+1 is the gray bit that toggles on this edge.
    // A wrap to zero, or any bit at or above N_CH-1, maps to the last channel.
    always_comb begin
        w_slot = CH_W'(N_CH-1);
        for (int k = N_CH-1; k >= 0; k--) begin
            if (w_cnt_inc[k]) begin
                w_slot = CH_W'(k);
            end
        end
    end

    always_comb begin
        w_clr = '0;
        if (en) begin
            w_clr[w_slot] = 1'b1;
        end
    end

    // A clear and a new edge on the same edge hand the old event to the
    // output and keep the new one pending, so neither is an overflow.
    assign w_pend_nxt = (r_pend & ~w_clr) | w_edge;
    assign w_pol_ld   = w_edge & (~r_pend | w_clr);
    assign w_pol_nxt  = (r_pol & ~w_pol_ld) | (r_pol0 & w_pol_ld);
    assign w_ovf_set  = w_edge & r_pend & ~w_clr;
    assign w_ovf_nxt  = (r_ovf & ~{N_CH{ovf_clr}}) | w_ovf_set;

    always_ff @(posedge clk_master or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
            r_pol  <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_pol  <= w_pol_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    always_ff @(posedge clk_master or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_gray      <= '0;
            r_out_ch    <= '0;
            r_out_eve   <= 1'b0;
            r_out_pol   <= 1'b0;
            r_out_frame <= 1'b0;
        end else if (en) begin
            r_cnt       <= w_cnt_inc;
            r_gray      <= w_cnt_inc ^ (w_cnt_inc >> 1);
            r_out_ch    <= w_slot;
            r_out_eve   <= r_pend[w_slot];
            r_out_pol   <= r_pend[w_slot] & r_pol[w_slot];
            r_out_frame <= &r_cnt;
        end else begin
            r_out_eve   <= 1'b0;
            r_out_pol   <= 1'b0;
            r_out_frame <= 1'b0;
        end
    end

    assign gray            = r_gray;
    assign out_mux_eve     = r_out_eve;
    assign out_mux_pol_eve = r_out_pol;
    assign out_ch          = r_out_ch;
    assign out_frame       = r_out_frame;
    assign ovf             = r_ovf;

endmodule

// File: tb/tb_ro_sched_mux.sv
// tb_ro_sched_mux: scenario tests plus randomized traffic for ro_sched_mux
// at N_CH=4, checked against a slot/pending reference model.

module tb_ro_sched_mux;

    localparam int N  = 4;
    localparam int FR = 16;
`ifdef RO_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic         clk;
    logic         reset;
    logic         en;
    logic [N-1:0] in_eve;
    logic [N-1:0] in_pol_eve;
    logic         ovf_clr;
    logic [N-1:0] gray;
    logic         out_mux_eve;
    logic         out_mux_pol_eve;
    logic [1:0]   out_ch;
    logic         out_frame;
    logic [N-1:0] ovf;

    int n_err;
    int n_chk;

    ro_sched_mux #(.N_CH(N)) dut (
        .clk_master      (clk),
        .reset           (reset),
        .en              (en),
        .in_eve          (in_eve),
        .in_pol_eve      (in_pol_eve),
        .ovf_clr         (ovf_clr),
        .gray            (gray),
        .out_mux_eve     (out_mux_eve),
        .out_mux_pol_eve (out_mux_pol_eve),
        .out_ch          (out_ch),
        .out_frame       (out_frame),
        .ovf             (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int           m_cnt;
    int           m_last_cnt;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_pol;
    logic [N-1:0] m_ovf;
    logic [N-1:0] h_e [3];
    logic [N-1:0] h_p [3];
    logic [1:0]   e_ch;
    logic         e_eve;
    logic         e_pol;
    logic         e_frame;
    logic [N-1:0] e_gray;

    function automatic int slot_of(int c);
        int v;
        int k;
        v = (c + 1) % FR;
        if (v == 0) return N - 1;
        k = 0;
        while (v % 2 == 0) begin
            v = v / 2;
            k++;
        end
        if (k > N - 1) k = N - 1;
        return k;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_last_cnt = -1;
        m_pend = '0;
        m_pol = '0;
        m_ovf = '0;
        for (int i = 0; i < 3; i++) begin
            h_e[i] = '0;
            h_p[i] = '0;
        end
        e_ch = '0;
        e_eve = 1'b0;
        e_pol = 1'b0;
        e_frame = 1'b0;
        e_gray = '0;
    endtask

    // h_e[i] holds the input sampled i+1 edges ago, so the newest
    // post-delay sample is h_e[D-1] and its predecessor h_e[D].
    task automatic model_step();
        int s;
        logic [N-1:0] rise;
        logic [N-1:0] newpol;
        logic [N-1:0] clr;
        rise = h_e[D-1] & ~h_e[D];
        newpol = h_p[D-1];
        clr = '0;
        if (en) begin
            s = slot_of(m_cnt);
            e_ch = 2'(s);
            e_eve = m_pend[s];
            e_pol = m_pend[s] & m_pol[s];
            e_frame = (m_cnt == FR - 1);
            clr[s] = 1'b1;
            m_last_cnt = m_cnt;
            m_cnt = (m_cnt + 1) % FR;
            e_gray = N'(m_cnt ^ (m_cnt >> 1));
        end else begin
            e_eve = 1'b0;
            e_pol = 1'b0;
            e_frame = 1'b0;
        end
        if (ovf_clr) m_ovf = '0;
        for (int k = 0; k < N; k++) begin
            if (rise[k]) begin
                if (m_pend[k] && !clr[k]) begin
                    m_ovf[k] = 1'b1;
                end else begin
                    m_pend[k] = 1'b1;
                    m_pol[k] = newpol[k];
                end
            end else if (clr[k]) begin
                m_pend[k] = 1'b0;
            end
        end
        h_e[2] = h_e[1];
        h_e[1] = h_e[0];
        h_e[0] = in_eve;
        h_p[2] = h_p[1];
        h_p[1] = h_p[0];
        h_p[0] = in_pol_eve;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    task automatic wait_cnt(input int v);
        for (int i = 0; i < 40; i++) begin
            if (m_cnt == v) break;
            @(negedge clk);
        end
        n_chk++;
        if (m_cnt != v) begin
            n_err++;
            $display("FAIL wait_cnt: timeout cnt=%0d want %0d", m_cnt, v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b1;
        in_eve = '0;
        in_pol_eve = '0;
        ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({gray, out_mux_eve, out_mux_pol_eve, out_ch, out_frame, ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_outs: got gray=%b eve=%b pol=%b ch=%0d fr=%b ovf=%b want all 0",
                     gray, out_mux_eve, out_mux_pol_eve, out_ch, out_frame, ovf);
        end
        reset = 1'b0;
    endtask

    task automatic test_schedule();
        int tbl [16] = '{0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,3};
        logic [N-1:0] prev_g;
        logic [N-1:0] want_diff;
        prev_g = '0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            n_chk++;
            if (out_ch !== 2'(tbl[i % 16])) begin
                n_err++;
                $display("FAIL sched_ch[%0d]: got %0d want %0d", i, out_ch, tbl[i % 16]);
            end
            n_chk++;
            if (out_frame !== ((i % 16) == 15)) begin
                n_err++;
                $display("FAIL sched_frame[%0d]: got %b want %b", i, out_frame, (i % 16) == 15);
            end
            want_diff = '0;
            want_diff[tbl[i % 16]] = 1'b1;
            n_chk++;
            if ((gray ^ prev_g) !== want_diff || gray !== e_gray) begin
                n_err++;
                $display("FAIL sched_gray[%0d]: got %b prev %b want %b", i, gray, prev_g, e_gray);
            end
            prev_g = gray;
        end
    endtask

    task automatic test_single_event();
        int hits;
        int hit_cnt;
        logic [1:0] hit_ch;
        logic hit_pol;
        hits = 0;
        hit_cnt = -1;
        hit_ch = '0;
        hit_pol = 1'b0;
        wait_cnt(4);
        in_eve[2] = 1'b1;
        in_pol_eve[2] = 1'b1;
        @(negedge clk);
        in_eve[2] = 1'b0;
        in_pol_eve[2] = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (out_mux_eve) begin
                hits++;
                hit_cnt = m_last_cnt;
                hit_ch = out_ch;
                hit_pol = out_mux_pol_eve;
            end
        end
        n_chk++;
        if (hits != 1 || hit_ch !== 2'd2 || hit_pol !== 1'b1 || hit_cnt != 11) begin
            n_err++;
            $display("FAIL single_event: got hits=%0d ch=%0d pol=%b cnt=%0d want 1 2 1 11",
                     hits, hit_ch, hit_pol, hit_cnt);
        end
    endtask

    task automatic test_overflow();
        int hits;
        logic hit_pol;
        hits = 0;
        hit_pol = 1'b0;
        wait_cnt(8);
        in_eve[3] = 1'b1;
        in_pol_eve[3] = 1'b1;
        @(negedge clk);
        in_eve[3] = 1'b0;
        in_pol_eve[3] = 1'b0;
        @(negedge clk);
        in_eve[3] = 1'b1;
        @(negedge clk);
        in_eve[3] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_mux_eve && out_ch == 2'd3) begin
                hits++;
                hit_pol = out_mux_pol_eve;
            end
        end
        n_chk++;
        if (hits != 1 || hit_pol !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_event: got hits=%0d pol=%b want 1 1", hits, hit_pol);
        end
        n_chk++;
        if (ovf !== 4'b1000) begin
            n_err++;
            $display("FAIL ovf_set: got %b want 1000", ovf);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_chk++;
        if (ovf !== 4'b0000) begin
            n_err++;
            $display("FAIL ovf_clr: got %b want 0000", ovf);
        end
    endtask

    task automatic test_collide();
        int seen;
        seen = 0;
        wait_cnt(6 - D);
        in_eve[0] = 1'b1;
        in_pol_eve[0] = 1'b1;
        @(negedge clk);
        in_eve[0] = 1'b0;
        in_pol_eve[0] = 1'b0;
        @(negedge clk);
        in_eve[0] = 1'b1;
        @(negedge clk);
        in_eve[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_last_cnt == 8) begin
                seen++;
                n_chk++;
                if (out_mux_eve !== 1'b1 || out_mux_pol_eve !== 1'b1 || out_ch !== 2'd0) begin
                    n_err++;
                    $display("FAIL collide_old: got eve=%b pol=%b ch=%0d want 1 1 0",
                             out_mux_eve, out_mux_pol_eve, out_ch);
                end
            end
            if (m_last_cnt == 10) begin
                seen++;
                n_chk++;
                if (out_mux_eve !== 1'b1 || out_mux_pol_eve !== 1'b0 || out_ch !== 2'd0) begin
                    n_err++;
                    $display("FAIL collide_new: got eve=%b pol=%b ch=%0d want 1 0 0",
                             out_mux_eve, out_mux_pol_eve, out_ch);
                end
                break;
            end
        end
        n_chk++;
        if (seen != 2 || ovf[0] !== 1'b0) begin
            n_err++;
            $display("FAIL collide_seen: got slots=%0d ovf0=%b want 2 0", seen, ovf[0]);
        end
    endtask

    task automatic test_enable();
        int hit_cnt;
        logic [1:0] hit_ch;
        logic hit_pol;
        hit_cnt = -1;
        hit_ch = '0;
        hit_pol = 1'b0;
        wait_cnt(1);
        in_eve[1] = 1'b1;
        in_pol_eve[1] = 1'b1;
        @(negedge clk);
        in_eve[1] = 1'b0;
        in_pol_eve[1] = 1'b0;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (gray !== 4'b0010 || out_mux_eve !== 1'b0 || out_ch !== 2'd0) begin
                n_err++;
                $display("FAIL en_hold[%0d]: got gray=%b eve=%b ch=%0d want 0010 0 0",
                         i, gray, out_mux_eve, out_ch);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_mux_eve) begin
                hit_cnt = m_last_cnt;
                hit_ch = out_ch;
                hit_pol = out_mux_pol_eve;
                break;
            end
        end
        n_chk++;
        if (hit_cnt != 5 || hit_ch !== 2'd1 || hit_pol !== 1'b1) begin
            n_err++;
            $display("FAIL en_resume: got cnt=%0d ch=%0d pol=%b want 5 1 1", hit_cnt, hit_ch, hit_pol);
        end
    endtask

    task automatic test_async_reset();
        int hits;
        int hit_cnt;
        logic [1:0] hit_ch;
        hits = 0;
        hit_cnt = -1;
        hit_ch = '0;
        wait_cnt(4);
        in_eve[2] = 1'b1;
        in_pol_eve[2] = 1'b1;
        @(negedge clk);
        in_eve[2] = 1'b0;
        in_pol_eve[2] = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_chk++;
        if ({gray, out_mux_eve, out_mux_pol_eve, out_ch, out_frame, ovf} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got gray=%b eve=%b pol=%b ch=%0d fr=%b ovf=%b want all 0",
                     gray, out_mux_eve, out_mux_pol_eve, out_ch, out_frame, ovf);
        end
        in_eve[0] = 1'b1;
        in_pol_eve[0] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_ch !== 2'd0 || out_mux_eve !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_first: got ch=%0d eve=%b want 0 0", out_ch, out_mux_eve);
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                in_eve[0] = 1'b0;
                in_pol_eve[0] = 1'b0;
            end
            @(negedge clk);
            if (out_mux_eve) begin
                hits++;
                hit_cnt = m_last_cnt;
                hit_ch = out_ch;
            end
        end
        n_chk++;
        if (hits != 1 || hit_ch !== 2'd0 || hit_cnt != ((D == 1) ? 2 : 4)) begin
            n_err++;
            $display("FAIL release_latency: got hits=%0d ch=%0d cnt=%0d want 1 0 %0d",
                     hits, hit_ch, hit_cnt, (D == 1) ? 2 : 4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_chk++;
            if (out_ch !== e_ch || out_mux_eve !== e_eve || out_mux_pol_eve !== e_pol
                || out_frame !== e_frame) begin
                n_err++;
                $display("FAIL rand_out[%0d]: got ch=%0d eve=%b pol=%b fr=%b want %0d %b %b %b",
                         i, out_ch, out_mux_eve, out_mux_pol_eve, out_frame,
                         e_ch, e_eve, e_pol, e_frame);
            end
            n_chk++;
            if (gray !== e_gray || ovf !== m_ovf) begin
                n_err++;
                $display("FAIL rand_state[%0d]: got gray=%b ovf=%b want %b %b",
                         i, gray, ovf, e_gray, m_ovf);
            end
            en = ($urandom % 8) != 0;
            ovf_clr = ($urandom % 16) == 0;
            for (int k = 0; k < N; k++) begin
                if ($urandom % 4 == 0) in_eve[k] = ~in_eve[k];
                in_pol_eve[k] = 1'($urandom % 2);
            end
        end
        en = 1'b1;
        ovf_clr = 1'b0;
        in_eve = '0;
        in_pol_eve = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        n_err = 0;
        n_chk = 0;
        reset = 1'b1;
        en = 1'b1;
        in_eve = '0;
        in_pol_eve = '0;
        ovf_clr = 1'b0;
        test_reset();
        test_schedule();
        test_single_event();
        test_overflow();
        test_collide();
        test_enable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ro_sched_mux.md
# ro_sched_mux

Parametrised time-division readout multiplexer for the cochlea channel bank. It captures rising-edge events and their polarity from `N_CH` channel cores and serialises them onto the shared `out_mux_eve`/`out_mux_pol_eve` pair. Slots follow an internal gray-counter schedule: channel k is read on the master edge where gray bit k toggles, so each channel is serviced at the rate of its octave-divided core clock. The block replaces fixed 8-channel readout chains; it adds pending-event buffering, a channel index, a frame marker and overflow flags.

## Interface
- `N_CH`, default 8: number of channels, legal range 2..16.
- `CH_W`, default `$clog2(N_CH)` (minimum 1): width of the channel index.
- `clk_master` in 1: single master clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: advance schedule when high.
- `in_eve` in N_CH: per-channel comparator event level from the cores.
- `in_pol_eve` in N_CH: per-channel polarity, sampled alongside `in_eve`.
- `ovf_clr` in 1: clears all overflow flags.
- `gray` out N_CH: registered gray code of the slot counter; drives the core clock dividers.
- `out_mux_eve` out 1: event present in the current slot.
- `out_mux_pol_eve` out 1: polarity of the event in the current slot, 0 when no event.
- `out_ch` out CH_W: channel serviced in the current slot.
- `out_frame` out 1: high for the last slot of each 2^N_CH-cycle frame.
- `ovf` out N_CH: sticky per-channel overflow flags.

## Operation
- Slot counter `cnt`, N_CH bits, binary, increments by 1 per edge while `en`=1 and wraps from 2^N_CH−1 to 0. `gray` = cnt ^ (cnt>>1), registered.
- Slot channel: s = ctz((cnt+1) mod 2^N_CH), clipped to N_CH−1; ctz(0) counts as N_CH. This is exactly the gray bit that toggles on that edge.
- Per frame, channel k<N_CH−1 gets 2^(N_CH−1−k) slots and channel N_CH−1 gets 2.
- Input path: `in_eve`/`in_pol_eve` pass through D sample stages to give r0 and pr0. r1 is r0 delayed one cycle. Event edge = r0 & ~r1.
- Pending store, per channel: `pend` bit and `pol` bit.
  - An event edge with `pend`=0 sets `pend` and loads `pol`<=pr0.
  - An event edge with `pend`=1, when the channel is not being cleared this edge, sets `ovf`. The edge is dropped and `pol` is kept.
- Service, on each edge with `en`=1:
  - `out_ch`<=s.
  - `out_mux_eve`<=pend[s].
  - `out_mux_pol_eve`<=pend[s]&pol[s].
  - `out_frame`<=(cnt==2^N_CH−1).
  - pend[s] is cleared.
- Simultaneous clear and new event edge on the same channel: the output carries the old event; `pend` stays 1 with the new polarity; no overflow.
- `en`=0: `cnt`, `gray` and `out_ch` hold. `out_mux_eve`, `out_mux_pol_eve` and `out_frame` are 0. Capture continues.
- `ovf_clr`=1 clears all `ovf` bits. A same-edge set has priority over the clear.

## Timing
- Reset values: all outputs 0; `cnt`, `pend`, `pol`, `ovf` and all sample/edge registers are 0.
- An input already high at reset release registers as one event.
- Reset asserted mid-frame clears all state immediately. Pending events are lost. The schedule restarts at cnt=0 on the first edge after release.
- Input-to-pending latency: D+1 edges after the first sampling edge (D=1, or D=2 with sync).
- Pending-to-output: the output appears on the slot edge and is valid for one cycle.
- Worst-case wait for channel k: 2^(k+1) cycles (k<N_CH−1); 2^(N_CH−1) cycles for channel N_CH−1.

## Configuration
- `RO_SYNC_EN` defined: D=2. Each `in_eve`/`in_pol_eve` bit gets a two-flop synchroniser, for asynchronous core-clock domains.
- `RO_SYNC_EN` undefined: D=1. Single sample flop; inputs must be synchronous to `clk_master`.

## Test plan
- N_CH=4, `en`=1, no events, 32 cycles:
  - `out_ch` sequence repeats 0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,3.
  - `out_frame`=1 only on the second ch3 slot.
  - `gray` follows 0,1,3,2,6,… with exactly bit `out_ch` changing per edge.
- N_CH=4, pulse `in_eve[2]`=1 with `in_pol_eve[2]`=1 while cnt=4:
  - Single `out_mux_eve`=1, `out_mux_pol_eve`=1, `out_ch`=2 on the slot from cnt=11.
  - No repeat in later slots.
- Two rising edges on ch3 before its slot:
  - One output event carrying the first polarity.
  - `ovf[3]`=1 until `ovf_clr` is pulsed, then 0.
- Event edge on ch0 landing on the same edge as its slot clear:
  - Output shows the prior event.
  - The next ch0 slot, 2 cycles later, shows the new one.
  - `ovf[0]` stays 0.
- `en`=0 for 5 cycles mid-frame with an event queued:
  - `gray` and `cnt` frozen; `out_mux_eve`=0.
  - After `en`=1 the event emits at its normal slot.
- Assert `reset` asynchronously mid-cycle with `pend` set:
  - All outputs are 0 immediately.
  - After release, `out_ch`=0 on the first edge and no stale event appears; repeat with `RO_SYNC_EN` and check the +1 cycle input latency.
